// File: rtl/step_sched_pkg.sv
// Shared definitions for the step scheduler: FSM state encodings and the
// default lower bound on the step period.
package step_sched_pkg;

    localparam int SS_MIN_PERIOD = 8;

    typedef enum logic [1:0] {
        SS_IDLE    = 2'd0,
        SS_ARMED   = 2'd1,
        SS_COMPUTE = 2'd2
    } ss_state_e;

endpackage

// File: rtl/step_sched.sv
// Step scheduler: issues periodic single-cycle step pulses to the compute block,
// flags overruns, and applies parameter-bank swaps only at step boundaries.
module step_sched
    import step_sched_pkg::*;
#(
    parameter int PERIOD_W   = 16,
    parameter int CNT_W      = 32,
    parameter int MIN_PERIOD = SS_MIN_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                single,
    input  logic [PERIOD_W-1:0] period,
    input  logic                comp_ready,
    input  logic                bank_swap_req,
    input  logic                clr_err,
    output logic                step,
    output logic                en,
    output logic                bank_sel,
    output logic                swap_ack,
    output logic                busy,
    output logic                overrun,
    output logic [CNT_W-1:0]    overrun_cnt,
    output logic [CNT_W-1:0]    step_cnt
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    ss_state_e           state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic                swap_pend_q, swap_pend_d;
    logic                step_q, en_q, busy_q, bank_sel_q, swap_ack_q, overrun_q;
    logic                bank_sel_d, overrun_d;
    logic [CNT_W-1:0]    overrun_cnt_q, overrun_cnt_d;
    logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;

    logic [PERIOD_W-1:0] eff_period;
    logic [PERIOD_W-1:0] reload_val;
    logic [PERIOD_W-1:0] timer_dec;
    logic                timer_zero;
    logic                issue;
    logic                ovr_evt;
    logic                swap_apply;

    assign eff_period = (period < MIN_P) ? MIN_P : period;
    assign reload_val = eff_period - PERIOD_W'(1);
    assign timer_zero = (timer_q == '0);
    assign timer_dec  = timer_zero ? '0 : timer_q - PERIOD_W'(1);

    // Next-state logic; comp_ready is evaluated before the timer so an on-time
    // completion at expiry launches the next step instead of counting an overrun.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        issue   = 1'b0;
        ovr_evt = 1'b0;
        case (state_q)
            SS_IDLE: begin
                if (run || single) begin
                    issue   = 1'b1;
                    timer_d = reload_val;
                    state_d = SS_COMPUTE;
                end
            end
            SS_ARMED: begin
                if (!run) begin
                    state_d = SS_IDLE;
                    timer_d = timer_dec;
                end else if (timer_zero) begin
                    issue   = 1'b1;
                    timer_d = reload_val;
                    state_d = SS_COMPUTE;
                end else begin
                    timer_d = timer_dec;
                end
            end
            SS_COMPUTE: begin
                if (comp_ready) begin
                    if (!run) begin
                        state_d = SS_IDLE;
                        timer_d = timer_dec;
                    end else if (timer_zero) begin
                        issue   = 1'b1;
                        timer_d = reload_val;
                    end else begin
                        state_d = SS_ARMED;
                        timer_d = timer_dec;
                    end
                end else if (timer_zero) begin
                    ovr_evt = 1'b1;
                    timer_d = reload_val;
                end else begin
                    timer_d = timer_dec;
                end
            end
            default: begin
                state_d = SS_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // A request landing in the same cycle as an application re-arms the pending flag.
    always_comb begin
        swap_apply  = swap_pend_q && ((state_q == SS_IDLE) || issue);
        swap_pend_d = bank_swap_req || (swap_pend_q && !swap_apply);
        bank_sel_d  = swap_apply ? !bank_sel_q : bank_sel_q;
        step_cnt_d  = step_cnt_q + CNT_W'(issue);

        overrun_d     = overrun_q;
        overrun_cnt_d = overrun_cnt_q;
        if (clr_err) begin
            overrun_d     = ovr_evt;
            overrun_cnt_d = CNT_W'(ovr_evt);
        end else if (ovr_evt) begin
            overrun_d     = 1'b1;
            overrun_cnt_d = (&overrun_cnt_q) ? overrun_cnt_q : overrun_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SS_IDLE;
            timer_q       <= '0;
            swap_pend_q   <= 1'b0;
            step_q        <= 1'b0;
            en_q          <= 1'b0;
            busy_q        <= 1'b0;
            bank_sel_q    <= 1'b0;
            swap_ack_q    <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
            step_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            swap_pend_q   <= swap_pend_d;
            step_q        <= issue;
            en_q          <= (state_d != SS_IDLE);
            busy_q        <= (state_d == SS_COMPUTE);
            bank_sel_q    <= bank_sel_d;
            swap_ack_q    <= swap_apply;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
            step_cnt_q    <= step_cnt_d;
        end
    end

    assign step        = step_q;
    assign en          = en_q;
    assign busy        = busy_q;
    assign bank_sel    = bank_sel_q;
    assign swap_ack    = swap_ack_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;
    assign step_cnt    = step_cnt_q;

endmodule

// File: tb/tb_step_sched.sv
// Self-checking bench for step_sched: expected step events are queued when the
// stimulus is driven and compared as the DUT emits step pulses.
module tb_step_sched;

    localparam int PW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          single = 1'b0;
    logic [PW-1:0] period = 16'd20;
    logic          comp_ready = 1'b0;
    logic          bank_swap_req = 1'b0;
    logic          clr_err = 1'b0;
    logic          step, en, bank_sel, swap_ack, busy, overrun;
    logic [CW-1:0] overrun_cnt, step_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int lat_cfg  = 10;
    int ready_at = -1;
    logic bank_m = 1'b0;

    typedef struct {
        int   t;
        logic bank;
        logic ack;
    } exp_t;
    exp_t sb[$];

    step_sched dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .single       (single),
        .period       (period),
        .comp_ready   (comp_ready),
        .bank_swap_req(bank_swap_req),
        .clr_err      (clr_err),
        .step         (step),
        .en           (en),
        .bank_sel     (bank_sel),
        .swap_ack     (swap_ack),
        .busy         (busy),
        .overrun      (overrun),
        .overrun_cnt  (overrun_cnt),
        .step_cnt     (step_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_cyc(input int t);
        if (t > cyc) tick(t - cyc);
    endtask

    task automatic push(input int t, input logic b, input logic a);
        exp_t e;
        e.t = t; e.bank = b; e.ack = a;
        sb.push_back(e);
    endtask

    // Scoreboard side: every observed step must match the oldest queued expectation.
    always @(negedge clk) begin
        if (step) begin
            if (sb.size() == 0) begin
                check("unexpected_step", cyc, -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("step_time", cyc, e.t);
                check("step_bank", bank_sel, e.bank);
                check("step_ack", swap_ack, e.ack);
            end
            $display("step @%0d step_cnt=%0d bank_sel=%0d swap_ack=%0d", cyc, step_cnt, bank_sel, swap_ack);
        end
        if (!rst) ready_at = -1;
        else if (step) ready_at = cyc + lat_cfg;
    end

    // Compute-block model: one comp_ready pulse lat_cfg cycles after each step.
    always @(posedge clk) begin
        #1;
        comp_ready = rst && (cyc == ready_at);
    end

    task automatic free_run(input int p, input int k);
        int s0;
        s0 = cyc + 1;
        run = 1'b1;
        for (int i = 0; i < k; i++) push(s0 + i * p, bank_m, 1'b0);
        to_cyc(s0 + (k - 1) * p + 1);
        run = 1'b0;
    endtask

    initial begin
        int s;
        int c;
        #1 rst = 1'b0;
        tick(3);
        check("rst_step", step, 0);
        check("rst_en", en, 0);
        check("rst_bank_sel", bank_sel, 0);
        check("rst_swap_ack", swap_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_overrun_cnt", overrun_cnt, 0);
        check("rst_step_cnt", step_cnt, 0);
        rst = 1'b1;
        tick(2);

        // Free run, period 20, completion 10 cycles after each step
        period = 16'd20; lat_cfg = 10;
        free_run(20, 5);
        tick(14);
        check("free_step_cnt", step_cnt, 5);
        check("free_overrun", overrun, 0);
        check("free_busy", busy, 0);
        check("free_en", en, 0);
        $display("free run done: step_cnt=%0d", step_cnt);

        // Overrun: two expiries before completion, completion at the third expiry steps at once
        period = 16'd10; lat_cfg = 29;
        s = cyc + 1;
        run = 1'b1;
        push(s, bank_m, 1'b0);
        push(s + 30, bank_m, 1'b0);
        tick(2);
        lat_cfg = 3;
        to_cyc(s + 31);
        run = 1'b0;
        check("ovr_flag", overrun, 1);
        check("ovr_cnt", overrun_cnt, 2);
        tick(8);
        check("ovr_busy", busy, 0);
        check("ovr_cnt_hold", overrun_cnt, 2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_cnt", overrun_cnt, 0);
        check("clr_flag", overrun, 0);
        check("ovr_step_cnt", step_cnt, 7);
        $display("overrun done: overrun_cnt cleared to %0d", overrun_cnt);

        // Clamp: programmed period 3 behaves as 8
        period = 16'd3; lat_cfg = 3;
        free_run(8, 4);
        tick(8);
        check("clamp_step_cnt", step_cnt, 11);
        $display("clamp done: step_cnt=%0d", step_cnt);

        // Swap mid-COMPUTE, plus a request colliding with an application
        period = 16'd12; lat_cfg = 4;
        s = cyc + 1;
        run = 1'b1;
        push(s, 1'b0, 1'b0);
        push(s + 12, 1'b1, 1'b1);
        push(s + 24, 1'b0, 1'b1);
        push(s + 36, 1'b0, 1'b0);
        to_cyc(s + 2);
        bank_swap_req = 1'b1;
        tick(1);
        bank_swap_req = 1'b0;
        to_cyc(s + 5);
        check("swap_held_bank", bank_sel, 0);
        check("swap_held_ack", swap_ack, 0);
        to_cyc(s + 11);
        bank_swap_req = 1'b1;
        tick(1);
        bank_swap_req = 1'b0;
        to_cyc(s + 37);
        run = 1'b0;
        tick(8);
        check("swap_busy", busy, 0);
        bank_m = 1'b0;

        // Swap requested in IDLE is applied one cycle later
        bank_swap_req = 1'b1;
        tick(1);
        bank_swap_req = 1'b0;
        check("idle_swap_pend_bank", bank_sel, 0);
        check("idle_swap_pend_ack", swap_ack, 0);
        tick(1);
        check("idle_swap_bank", bank_sel, 1);
        check("idle_swap_ack", swap_ack, 1);
        tick(1);
        check("idle_swap_ack_pulse", swap_ack, 0);
        check("idle_swap_bank_hold", bank_sel, 1);
        bank_m = 1'b1;
        $display("idle swap done: bank_sel=%0d", bank_sel);

        // Single step; a second single while busy is ignored
        period = 16'd20; lat_cfg = 6;
        c = cyc;
        single = 1'b1;
        push(c + 1, bank_m, 1'b0);
        tick(1);
        single = 1'b0;
        check("single_busy", busy, 1);
        check("single_en", en, 1);
        tick(1);
        single = 1'b1;
        tick(1);
        single = 1'b0;
        to_cyc(c + 10);
        check("single_idle_busy", busy, 0);
        check("single_idle_en", en, 0);
        check("single_step_cnt", step_cnt, 16);
        $display("single step done: step_cnt=%0d", step_cnt);

        // Async reset mid-COMPUTE with a swap pending
        lat_cfg = 10;
        s = cyc + 1;
        run = 1'b1;
        push(s, bank_m, 1'b0);
        tick(2);
        bank_swap_req = 1'b1;
        tick(1);
        bank_swap_req = 1'b0;
        tick(1);
        #3 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_en", en, 0);
        check("arst_bank_sel", bank_sel, 0);
        check("arst_step_cnt", step_cnt, 0);
        check("arst_step", step, 0);
        check("arst_swap_ack", swap_ack, 0);
        bank_m = 1'b0;
        #2;
        c = cyc;
        push(c + 1, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        run = 1'b0;
        tick(1);
        check("arst_restart_cnt", step_cnt, 1);
        tick(14);
        check("final_busy", busy, 0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
